vend_sequencer: RTL and testbench

Transaction sequencer for the vending machine. It accumulates coin credit, checks a product selection against its price, runs a request/acknowledge handshake with the dispense mechanism, and then pays back the remaining credit one $5 coin at a time through a change hopper. It sits between the coin acceptor and keypad on one side and the dispense motor and change hopper on the other, and owns the credit register.

---
 rtl/vend_sequencer_if.sv | 15 +
 rtl/vend_sequencer.sv | 109 ++++++++++
 tb/tb_vend_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: coin/keypad/mechanism handshake bundle between the vending sequencer and its environment
interface vend_sequencer_if #(parameter int CREDIT_W = 6);
  logic [1:0] coin;
  logic select_valid, select_product, cancel, dispense_ack, change_ack;
  logic dispense_req, dispense_product, change_req, coin_reject, short_credit, vend_done, fault, busy;
  logic [CREDIT_W-1:0] credit;
  modport master (
    output coin, select_valid, select_product, cancel, dispense_ack, change_ack,
    input dispense_req, dispense_product, change_req, credit, coin_reject, short_credit, vend_done, fault, busy
  );
  modport slave (
    input coin, select_valid, select_product, cancel, dispense_ack, change_ack,
    output dispense_req, dispense_product, change_req, credit, coin_reject, short_credit, vend_done, fault, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation, price check, dispense handshake with timeout, and $5 change payout
module vend_sequencer #(
  parameter int PRICE_CHOCO = 15,
  parameter int PRICE_DRINK = 10,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W = 6,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  vend_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W:0] P_CHOCO = PRICE_CHOCO[CREDIT_W:0];
  localparam logic [CREDIT_W:0] P_DRINK = PRICE_DRINK[CREDIT_W:0];
  localparam logic [CREDIT_W:0] MAX = MAX_CREDIT[CREDIT_W:0];
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, PAYOUT} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic [TW-1:0] cnt, cnt_n;
  logic prod, prod_n, dreq, creq, rej, rej_n, short, short_n, done, done_n, flt, flt_n, busy;
  logic accepting, coin_ok;
  logic [CREDIT_W:0] coin_val, sum, acc, sel_price, held_price, after_sel, restored;
  always_comb begin
    accepting = state == IDLE || state == CREDIT;
    coin_val = bus.coin == 2'b01 ? (CREDIT_W+1)'(5) : bus.coin == 2'b10 ? (CREDIT_W+1)'(10) : '0;
    sum = {1'b0, credit} + coin_val;
    coin_ok = accepting && coin_val != '0 && sum <= MAX;
    acc = coin_ok ? sum : {1'b0, credit};
    sel_price = bus.select_product ? P_DRINK : P_CHOCO;
    held_price = prod ? P_DRINK : P_CHOCO;
    after_sel = acc - sel_price;
    restored = {1'b0, credit} + held_price;
    state_n = state;
    credit_n = credit;
    cnt_n = cnt;
    prod_n = prod;
    rej_n = bus.coin != 2'b00 && !coin_ok;
    short_n = 1'b0;
    done_n = 1'b0;
    flt_n = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        credit_n = acc[CREDIT_W-1:0];
        if (state == CREDIT && bus.cancel) state_n = PAYOUT;
        else if (bus.select_valid && {1'b0, credit} >= sel_price) begin
          state_n = DISPENSE;
          prod_n = bus.select_product;
          credit_n = after_sel[CREDIT_W-1:0];
          cnt_n = '0;
        end else begin
          short_n = bus.select_valid;
          state_n = acc != '0 ? CREDIT : IDLE;
        end
      end
      DISPENSE: begin
        if (bus.dispense_ack) begin
          done_n = 1'b1;
          state_n = credit != '0 ? PAYOUT : IDLE;
        end else if (cnt == T_LAST) begin
          // a timed-out vend refunds the price so the customer is paid back in full
          flt_n = 1'b1;
          credit_n = restored[CREDIT_W-1:0];
          state_n = PAYOUT;
        end else cnt_n = cnt + 1'b1;
      end
      default: begin
        if (creq && bus.change_ack) credit_n = credit - CREDIT_W'(5);
        if (credit_n == '0) state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      cnt <= '0;
      prod <= 1'b0;
      dreq <= 1'b0;
      creq <= 1'b0;
      rej <= 1'b0;
      short <= 1'b0;
      done <= 1'b0;
      flt <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      cnt <= cnt_n;
      prod <= prod_n;
      dreq <= state_n == DISPENSE;
      creq <= state_n == PAYOUT && credit_n != '0;
      rej <= rej_n;
      short <= short_n;
      done <= done_n;
      flt <= flt_n;
      busy <= state_n == DISPENSE || state_n == PAYOUT;
    end
  assign bus.dispense_req = dreq;
  assign bus.dispense_product = prod;
  assign bus.change_req = creq;
  assign bus.credit = credit;
  assign bus.coin_reject = rej;
  assign bus.short_credit = short;
  assign bus.vend_done = done;
  assign bus.fault = flt;
  assign bus.busy = busy;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed test-plan steps plus random traffic, checked against a transaction-level model
module tb_vend_sequencer;
  localparam int MAXC = 40;
  localparam int TMO = 255;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_ph = 0;
  int m_credit = 0;
  int m_prod = 0;
  int m_wait = 0;
  int e_rej = 0, e_short = 0, e_done = 0, e_fault = 0;
  vend_sequencer_if #(.CREDIT_W(6)) bus ();
  vend_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input int exp);
    checks++;
    assert (got === 8'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("credit", 8'(bus.credit), m_credit);
    chk("dispense_req", 8'(bus.dispense_req), int'(m_ph == 2));
    chk("dispense_product", 8'(bus.dispense_product), m_prod);
    chk("change_req", 8'(bus.change_req), int'(m_ph == 3 && m_credit > 0));
    chk("busy", 8'(bus.busy), int'(m_ph >= 2));
    chk("coin_reject", 8'(bus.coin_reject), e_rej);
    chk("short_credit", 8'(bus.short_credit), e_short);
    chk("vend_done", 8'(bus.vend_done), e_done);
    chk("fault", 8'(bus.fault), e_fault);
  endtask
  // phases: 0 idle, 1 holding credit, 2 waiting on mechanism, 3 returning change
  task automatic model(input int c, input int sv, input int sp, input int cn, input int da, input int ca);
    int cv, acc, pr;
    cv = c == 1 ? 5 : c == 2 ? 10 : 0;
    pr = sp != 0 ? 10 : 15;
    e_rej = 0; e_short = 0; e_done = 0; e_fault = 0;
    if (m_ph < 2) begin
      acc = m_credit;
      if (c == 3 || (cv > 0 && m_credit + cv > MAXC)) e_rej = 1;
      else acc += cv;
      if (m_ph == 1 && cn != 0) begin
        m_credit = acc; m_ph = 3;
      end else if (sv != 0 && m_credit >= pr) begin
        m_credit = acc - pr; m_prod = sp; m_ph = 2; m_wait = 0;
      end else begin
        e_short = sv; m_credit = acc; m_ph = acc > 0 ? 1 : 0;
      end
    end else begin
      e_rej = int'(c != 0);
      if (m_ph == 2) begin
        m_wait++;
        if (da != 0) begin
          e_done = 1; m_ph = m_credit > 0 ? 3 : 0;
        end else if (m_wait == TMO) begin
          e_fault = 1; m_credit += m_prod != 0 ? 10 : 15; m_ph = 3;
        end
      end else begin
        if (m_credit > 0 && ca != 0) m_credit -= 5;
        if (m_credit == 0) m_ph = 0;
      end
    end
  endtask
  task automatic step(input int c, input int sv, input int sp, input int cn, input int da, input int ca);
    bus.coin = 2'(c);
    bus.select_valid = sv[0];
    bus.select_product = sp[0];
    bus.cancel = cn[0];
    bus.dispense_ack = da[0];
    bus.change_ack = ca[0];
    @(posedge clk);
    model(c, sv, sp, cn, da, ca);
    #1;
    check_all();
  endtask
  task automatic idle_inputs();
    bus.coin = 2'b00;
    bus.select_valid = 1'b0;
    bus.select_product = 1'b0;
    bus.cancel = 1'b0;
    bus.dispense_ack = 1'b0;
    bus.change_ack = 1'b0;
  endtask
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    m_ph = 0; m_credit = 0; m_prod = 0; m_wait = 0;
    e_rej = 0; e_short = 0; e_done = 0; e_fault = 0;
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    chk("plan1_credit5", 8'(bus.credit), 5);
    step(2, 0, 0, 0, 0, 0);
    chk("plan1_credit15", 8'(bus.credit), 15);
    step(0, 1, 0, 0, 0, 0);
    chk("plan1_req", 8'(bus.dispense_req), 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("plan1_done", 8'(bus.vend_done), 1);
    step(0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("plan2_credit10", 8'(bus.credit), 10);
    step(0, 0, 0, 0, 1, 0);
    chk("plan2_change_req", 8'(bus.change_req), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("plan2_credit0", 8'(bus.credit), 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    chk("plan3_over_reject", 8'(bus.coin_reject), 1);
    chk("plan3_credit35", 8'(bus.credit), 35);
    step(3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
    step(2, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("plan3_short", 8'(bus.short_credit), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("plan4_credit15", 8'(bus.credit), 15);
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("plan4_credit0", 8'(bus.credit), 0);
    step(2, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < TMO; i++) step(0, 0, 0, 0, 0, 0);
    chk("plan5_fault", 8'(bus.fault), 1);
    chk("plan5_credit20", 8'(bus.credit), 20);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
    step(2, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    chk("plan6_coin_after_reset", 8'(bus.credit), 5);
    step(0, 0, 0, 1, 0, 0);
    do_reset();
    step(2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      step(r < 4 ? 0 : r - 4, int'($urandom_range(0, 4) == 0), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)));
      if (i % 1000 == 999) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
